// File: rtl/adjacency_list_store.sv
// adjacency_list_store: per-source linked-list edge store with a streaming
// successor-query reply channel. Edges can arrive in any source order. Once
// decoding is done, each query streams the successors of one node in the
// order their edges were inserted.
module adjacency_list_store #(
  parameter int MAX_NODES  = 1024,
  parameter int MAX_EDGES  = 2048,
  parameter int NODE_WIDTH = $clog2(MAX_NODES),
  parameter int CNT_WIDTH  = $clog2(MAX_EDGES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  decoding_done,
  input  logic                  edge_valid,
  input  logic [NODE_WIDTH-1:0] src_node,
  input  logic [NODE_WIDTH-1:0] dst_node,
  output logic                  query_ready,
  input  logic                  query_valid,
  input  logic [NODE_WIDTH-1:0] query_data,
  input  logic                  reply_ready,
  output logic                  reply_valid,
  output logic [NODE_WIDTH-1:0] reply_data,
  output logic                  reply_last,
  output logic                  reply_no_edges_found,
  output logic [CNT_WIDTH-1:0]  reply_degree,
  output logic [CNT_WIDTH-1:0]  edge_count,
  output logic                  overflow
);

  // Width of an index into the edge array.
  localparam int EW = (MAX_EDGES > 1) ? $clog2(MAX_EDGES) : 1;

  typedef enum logic [1:0] {
    S_BUILD  = 2'd0,
    S_IDLE   = 2'd1,
    S_LOOKUP = 2'd2,
    S_REPLY  = 2'd3
  } state_t;

  state_t r_state;

  // Node table and edge array: plain storage, not reset.
  logic [EW-1:0]         r_head       [MAX_NODES];
  logic [EW-1:0]         r_tail       [MAX_NODES];
  logic [CNT_WIDTH-1:0]  r_degree_tab [MAX_NODES];
  logic [NODE_WIDTH-1:0] r_edge_dst   [MAX_EDGES];
  logic [EW-1:0]         r_edge_next  [MAX_EDGES];

  // Validity bitmap for the node table; reset wipes the whole graph.
  logic [MAX_NODES-1:0]  r_has_edges;
  logic [CNT_WIDTH-1:0]  r_edge_count;
  logic                  r_overflow;

  // Query and reply registers.
  logic [NODE_WIDTH-1:0] r_query_node;
  logic [CNT_WIDTH-1:0]  r_remaining;
  logic [EW-1:0]         r_next_ptr;
  logic                  r_query_ready;
  logic                  r_reply_valid;
  logic [NODE_WIDTH-1:0] r_reply_data;
  logic                  r_reply_last;
  logic                  r_no_edges;
  logic [CNT_WIDTH-1:0]  r_reply_degree;

  logic                  w_has_room;
  logic                  w_insert;
  logic                  w_drop;
  logic                  w_src_has;
  logic [EW-1:0]         w_new_idx;
  logic                  w_q_has;
  logic [EW-1:0]         w_q_head;
  logic [CNT_WIDTH-1:0]  w_q_deg;

  // The allocation pointer is the edge count itself.
  assign w_has_room = (r_edge_count < CNT_WIDTH'(MAX_EDGES));
  assign w_insert   = edge_valid && (r_state == S_BUILD) && w_has_room;
  assign w_drop     = edge_valid && !w_insert;
  assign w_new_idx  = r_edge_count[EW-1:0];
  assign w_src_has  = r_has_edges[src_node];
  assign w_q_has    = r_has_edges[r_query_node];
  assign w_q_head   = r_head[r_query_node];
  assign w_q_deg    = r_degree_tab[r_query_node];

  // Append the new edge to its source's list; the old tail's next pointer and
  // the new tail are both updated in the same cycle so back-to-back edges on
  // one source chain correctly.
  always_ff @(posedge clk) begin
    if (w_insert) begin
      r_edge_dst[w_new_idx] <= dst_node;
      if (w_src_has) begin
        r_edge_next[r_tail[src_node]] <= w_new_idx;
        r_degree_tab[src_node]        <= r_degree_tab[src_node] + CNT_WIDTH'(1);
      end else begin
        r_head[src_node]       <= w_new_idx;
        r_degree_tab[src_node] <= CNT_WIDTH'(1);
      end
      r_tail[src_node] <= w_new_idx;
    end
  end

  // Bitmap, edge counter and sticky drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_has_edges  <= '0;
      r_edge_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_insert) begin
        r_has_edges[src_node] <= 1'b1;
        r_edge_count          <= r_edge_count + CNT_WIDTH'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Control FSM: build, accept a query, fetch the list head, stream beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_BUILD;
      r_query_node   <= '0;
      r_remaining    <= '0;
      r_next_ptr     <= '0;
      r_query_ready  <= 1'b0;
      r_reply_valid  <= 1'b0;
      r_reply_data   <= '0;
      r_reply_last   <= 1'b0;
      r_no_edges     <= 1'b0;
      r_reply_degree <= '0;
    end else begin
      case (r_state)
        S_BUILD: begin
          if (decoding_done) begin
            r_state       <= S_IDLE;
            r_query_ready <= 1'b1;
          end
        end
        S_IDLE: begin
          if (query_valid) begin
            r_query_node  <= query_data;
            r_query_ready <= 1'b0;
            r_state       <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          r_reply_valid <= 1'b1;
          r_state       <= S_REPLY;
          if (w_q_has) begin
            r_reply_data   <= r_edge_dst[w_q_head];
            r_next_ptr     <= r_edge_next[w_q_head];
            r_remaining    <= w_q_deg;
            r_reply_degree <= w_q_deg;
            r_reply_last   <= (w_q_deg == CNT_WIDTH'(1));
            r_no_edges     <= 1'b0;
          end else begin
            // A node with no edges still gets exactly one marker beat.
            r_reply_data   <= '0;
            r_next_ptr     <= '0;
            r_remaining    <= CNT_WIDTH'(1);
            r_reply_degree <= '0;
            r_reply_last   <= 1'b1;
            r_no_edges     <= 1'b1;
          end
        end
        S_REPLY: begin
          if (r_reply_valid && reply_ready) begin
            if (r_reply_last) begin
              r_reply_valid <= 1'b0;
              r_reply_last  <= 1'b0;
              r_no_edges    <= 1'b0;
              r_query_ready <= 1'b1;
              r_state       <= S_IDLE;
            end else begin
              r_reply_data <= r_edge_dst[r_next_ptr];
              r_next_ptr   <= r_edge_next[r_next_ptr];
              r_remaining  <= r_remaining - CNT_WIDTH'(1);
              r_reply_last <= (r_remaining == CNT_WIDTH'(2));
            end
          end
        end
        default: begin
          r_state       <= S_BUILD;
          r_query_ready <= 1'b0;
          r_reply_valid <= 1'b0;
          r_reply_last  <= 1'b0;
        end
      endcase
    end
  end

  assign query_ready          = r_query_ready;
  assign reply_valid          = r_reply_valid;
  assign reply_data           = r_reply_data;
  assign reply_last           = r_reply_last;
  assign reply_no_edges_found = r_no_edges;
  assign reply_degree         = r_reply_degree;
  assign edge_count           = r_edge_count;
  assign overflow             = r_overflow;

endmodule

// File: tb/tb_adjacency_list_store.sv
// Self-checking bench for adjacency_list_store: a queue-per-node graph model
// predicts edge_count/overflow and every reply beat; directed scenarios pin
// the model with literal expectations, then randomized builds and queries.
module tb_adjacency_list_store;
  localparam int MN = 16;
  localparam int ME = 4;
  localparam int NW = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          decoding_done = 1'b0;
  logic          edge_valid = 1'b0;
  logic [NW-1:0] src_node = '0;
  logic [NW-1:0] dst_node = '0;
  logic          query_ready;
  logic          query_valid = 1'b0;
  logic [NW-1:0] query_data = '0;
  logic          reply_ready = 1'b0;
  logic          reply_valid;
  logic [NW-1:0] reply_data;
  logic          reply_last;
  logic          reply_no_edges_found;
  logic [CW-1:0] reply_degree;
  logic [CW-1:0] edge_count;
  logic          overflow;

  adjacency_list_store #(.MAX_NODES(MN), .MAX_EDGES(ME)) dut (
    .clk(clk), .rst_n(rst_n), .decoding_done(decoding_done),
    .edge_valid(edge_valid), .src_node(src_node), .dst_node(dst_node),
    .query_ready(query_ready), .query_valid(query_valid), .query_data(query_data),
    .reply_ready(reply_ready), .reply_valid(reply_valid), .reply_data(reply_data),
    .reply_last(reply_last), .reply_no_edges_found(reply_no_edges_found),
    .reply_degree(reply_degree), .edge_count(edge_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    bit last;
    bit noe;
    int deg;
  } beat_t;

  // Behavioural model: successor list per node, in insertion order.
  int    m_adj [MN][$];
  int    m_count;
  bit    m_ovf;
  bit    m_build;
  beat_t exp_q [$];
  int    got_q [$];
  bit    got_last_q [$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    pat [5] = '{1, 0, 0, 1, 1};

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Compare process: counters every cycle, reply fields whenever a beat is shown.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("edge_count", edge_count, m_count);
      chk("overflow", overflow, m_ovf);
      if (reply_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_beat: reply_valid=1 data=%0d with no beat outstanding", reply_data);
        end else begin
          chk("reply_data", reply_data, exp_q[0].data);
          chk("reply_last", reply_last, exp_q[0].last);
          chk("reply_no_edges", reply_no_edges_found, exp_q[0].noe);
          chk("reply_degree", reply_degree, exp_q[0].deg);
          if (reply_ready) begin
            got_q.push_back(reply_data);
            got_last_q.push_back(reply_last);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  function automatic bit ready_val(input int mode, input int idx);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (idx < 5) ? pat[idx][0] : 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic model_clear();
    foreach (m_adj[i]) m_adj[i].delete();
    m_count = 0;
    m_ovf   = 1'b0;
    m_build = 1'b1;
    exp_q.delete();
    got_q.delete();
    got_last_q.delete();
  endtask

  // Asserts reset off-edge and checks that outputs drop at once.
  task automatic do_reset();
    rst_n = 1'b0;
    edge_valid = 1'b0;
    query_valid = 1'b0;
    reply_ready = 1'b0;
    decoding_done = 1'b0;
    model_clear();
    #1;
    chk("rst_query_ready", query_ready, 0);
    chk("rst_reply_valid", reply_valid, 0);
    chk("rst_reply_last", reply_last, 0);
    chk("rst_reply_data", reply_data, 0);
    chk("rst_no_edges", reply_no_edges_found, 0);
    chk("rst_reply_degree", reply_degree, 0);
    chk("rst_edge_count", edge_count, 0);
    chk("rst_overflow", overflow, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_edge(input int s, input int d, input bit done);
    edge_valid = 1'b1;
    src_node = NW'(s);
    dst_node = NW'(d);
    if (done) decoding_done = 1'b1;
    @(posedge clk);
    if (m_build && m_count < ME) begin
      m_adj[s].push_back(d);
      m_count++;
    end else begin
      m_ovf = 1'b1;
    end
    if (decoding_done) m_build = 1'b0;
    #1 edge_valid = 1'b0;
  endtask

  task automatic finish_build();
    if (m_build) begin
      decoding_done = 1'b1;
      @(posedge clk);
      m_build = 1'b0;
      #1;
    end
    @(negedge clk);
    chk("query_ready_after_done", query_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected(input int node);
    int n;
    n = m_adj[node].size();
    if (n == 0) begin
      exp_q.push_back(beat_t'{data: 0, last: 1'b1, noe: 1'b1, deg: 0});
    end else begin
      for (int i = 0; i < n; i++)
        exp_q.push_back(beat_t'{data: m_adj[node][i], last: (i == n - 1), noe: 1'b0, deg: n});
    end
  endtask

  task automatic do_query(input int node, input int mode, input bit poke);
    int idx;
    int budget;
    got_q.delete();
    got_last_q.delete();
    chk("query_ready_idle", query_ready, 1);
    query_valid = 1'b1;
    query_data = NW'(node);
    @(posedge clk);
    push_expected(node);
    #1 query_valid = 1'b0;
    reply_ready = ready_val(mode, 0);
    @(negedge clk);
    chk("reply_valid_lookup", reply_valid, 0);
    @(negedge clk);
    chk("reply_valid_first", reply_valid, 1);
    #1;
    idx = 1;
    budget = 0;
    do begin
      @(posedge clk);
      #1;
      reply_ready = ready_val(mode, idx);
      idx++;
      budget++;
      if (poke) begin
        query_valid = 1'($urandom_range(0, 1));
        query_data = NW'($urandom_range(0, MN - 1));
      end
    end while (exp_q.size() > 0 && budget < 64);
    chk("reply_complete", exp_q.size(), 0);
    exp_q.delete();
    reply_ready = 1'b0;
    query_valid = 1'b0;
    @(negedge clk);
    chk("query_ready_after_reply", query_ready, 1);
    chk("reply_valid_after_reply", reply_valid, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    do_reset();

    // Interleaved sources, last edge in the same cycle as decoding_done.
    send_edge(5, 7, 1'b0);
    send_edge(3, 1, 1'b0);
    send_edge(5, 9, 1'b1);
    finish_build();
    send_edge(2, 2, 1'b0);
    @(negedge clk);
    chk("lit_count_3", edge_count, 3);
    chk("lit_ovf_after_idle_edge", overflow, 1);
    @(posedge clk);
    #1;
    do_query(5, 0, 1'b0);
    chk("lit_q5_beats", got_q.size(), 2);
    chk("lit_q5_b0", got_q[0], 7);
    chk("lit_q5_b1", got_q[1], 9);
    chk("lit_q5_last0", got_last_q[0], 0);
    chk("lit_q5_last1", got_last_q[1], 1);
    do_query(3, 0, 1'b0);
    chk("lit_q3_beats", got_q.size(), 1);
    chk("lit_q3_b0", got_q[0], 1);
    do_query(12, 0, 1'b0);
    chk("lit_q12_beats", got_q.size(), 1);
    chk("lit_q12_b0", got_q[0], 0);

    // Capacity overflow, then a stalled degree-3 reply with queries poked in.
    do_reset();
    send_edge(1, 2, 1'b0);
    send_edge(1, 3, 1'b0);
    send_edge(4, 5, 1'b0);
    send_edge(1, 6, 1'b0);
    send_edge(7, 8, 1'b0);
    send_edge(1, 9, 1'b0);
    finish_build();
    chk("lit_count_full", edge_count, 4);
    chk("lit_ovf_full", overflow, 1);
    do_query(1, 1, 1'b1);
    chk("lit_q1_beats", got_q.size(), 3);
    chk("lit_q1_b0", got_q[0], 2);
    chk("lit_q1_b1", got_q[1], 3);
    chk("lit_q1_b2", got_q[2], 6);
    do_query(4, 2, 1'b0);
    chk("lit_q4_b0", got_q[0], 5);
    do_query(7, 0, 1'b0);
    chk("lit_q7_b0", got_q[0], 0);

    // Reset in the middle of a stalled reply, then rebuild a new graph.
    do_reset();
    send_edge(6, 11, 1'b0);
    send_edge(6, 12, 1'b0);
    send_edge(0, 3, 1'b0);
    finish_build();
    query_valid = 1'b1;
    query_data = NW'(6);
    @(posedge clk);
    push_expected(6);
    #1 query_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midreply_valid_before_rst", reply_valid, 1);
    #2;
    do_reset();
    send_edge(6, 1, 1'b0);
    send_edge(8, 2, 1'b0);
    finish_build();
    do_query(6, 0, 1'b0);
    chk("lit_rebuild_q6_beats", got_q.size(), 1);
    chk("lit_rebuild_q6_b0", got_q[0], 1);
    do_query(0, 0, 1'b0);
    chk("lit_rebuild_q0_b0", got_q[0], 0);

    // Randomized builds and queries against the model.
    repeat (40) begin
      do_reset();
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          @(posedge clk);
          #1;
        end
        send_edge($urandom_range(0, 3), $urandom_range(0, MN - 1),
                  (i == n - 1) && ($urandom_range(0, 1) == 1));
      end
      finish_build();
      if ($urandom_range(0, 1) == 1) send_edge($urandom_range(0, 3), $urandom_range(0, MN - 1), 1'b0);
      repeat (4) do_query($urandom_range(0, 5), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
